// File: rtl/sand_pkg.sv
// Shared types and helpers for the sand row stepper.
// Cell encoding and single-cell pack/unpack helpers used to slice
// 2*CELLS-bit framebuffer words into cells (cell i = bits[2i+1:2i]).
package sand_pkg;

    typedef enum logic [1:0] {
        AIR     = 2'b00,
        SAND    = 2'b01,
        SAND_AM = 2'b10,   // sand that has already moved this pass
        WALL    = 2'b11
    } cell_t;

    function automatic cell_t unpack_cell(input logic [1:0] bits);
        return cell_t'(bits);
    endfunction

    function automatic logic [1:0] pack_cell(input cell_t c);
        return c;
    endfunction

endpackage

// File: rtl/sand_row_stepper_if.sv
// Stream interface of the sand row stepper.
// Input side : dir_seed, in_valid/in_ready, in_region, in_floor, in_first, in_last
// Output side: out_valid/out_ready, out_region, out_floor, out_first, out_last,
//              row_done, moved_count
// master = producer/consumer around the engine, slave = the engine itself.
interface sand_row_stepper_if #(
    parameter int CELLS = 16,
    parameter int CNT_W = 12
);
    logic                 dir_seed;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*CELLS-1:0]   in_region;
    logic [2*CELLS-1:0]   in_floor;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*CELLS-1:0]   out_region;
    logic [2*CELLS-1:0]   out_floor;
    logic                 out_first;
    logic                 out_last;
    logic                 row_done;
    logic [CNT_W-1:0]     moved_count;

    modport master (
        output dir_seed, in_valid, in_region, in_floor, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_region, out_floor, out_first, out_last,
               row_done, moved_count
    );

    modport slave (
        input  dir_seed, in_valid, in_region, in_floor, in_first, in_last, out_ready,
        output in_ready, out_valid, out_region, out_floor, out_first, out_last,
               row_done, moved_count
    );
endinterface

// File: rtl/sand_word_kernel.sv
// Combinational sand update for one word of a region row over its floor row.
// Ports:
//   cur_region/cur_floor : incoming word pair (cell CELLS-1 is leftmost)
//   lookahead            : floor cell just right of cell 0 (WALL at row end)
//   pref                 : tie-break preference on entry (0=left, 1=right)
//   new_region/new_floor : updated word pair
//   carry                : grain of cell 0 slid into the next word's leftmost floor cell
//   pref_next            : tie-break preference after this word
//   moves                : number of grains moved in this word
module sand_word_kernel
    import sand_pkg::*;
#(
    parameter int CELLS = 16,
    parameter int MW    = $clog2(CELLS + 1)
) (
    input  logic [2*CELLS-1:0] cur_region,
    input  logic [2*CELLS-1:0] cur_floor,
    input  cell_t              lookahead,
    input  logic               pref,
    output logic [2*CELLS-1:0] new_region,
    output logic [2*CELLS-1:0] new_floor,
    output logic               carry,
    output logic               pref_next,
    output logic [MW-1:0]      moves
);

    cell_t         r_s [CELLS];
    cell_t         f_s [CELLS];
    logic          p_s;
    logic          carry_s;
    logic          l_air_s;
    logic          r_air_s;
    logic          take_l_s;
    logic          take_r_s;
    logic [MW-1:0] mv_s;

    // Sweep cells left to right on a working floor copy so earlier moves block later ones.
    always_comb begin
        for (int i = 0; i < CELLS; i++) begin
            r_s[i] = unpack_cell(cur_region[2*i +: 2]);
            f_s[i] = unpack_cell(cur_floor[2*i +: 2]);
        end
        p_s      = pref;
        carry_s  = 1'b0;
        mv_s     = '0;
        l_air_s  = 1'b0;
        r_air_s  = 1'b0;
        take_l_s = 1'b0;
        take_r_s = 1'b0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            // Neighbour indices are clamped so they stay in range; the edge
            // cases are masked by the i tests.
            l_air_s  = (i != CELLS - 1) && (f_s[(i == CELLS - 1) ? 0 : i + 1] == AIR);
            r_air_s  = (i == 0) ? ((lookahead == AIR) && !carry_s)
                                : (f_s[(i == 0) ? 0 : i - 1] == AIR);
            take_l_s = 1'b0;
            take_r_s = 1'b0;
            case (r_s[i])
                SAND_AM: r_s[i] = SAND;
                SAND: begin
                    if (f_s[i] == AIR) begin
                        r_s[i] = AIR;
                        f_s[i] = SAND_AM;
                        mv_s   = mv_s + MW'(1);
                    end else begin
                        if (l_air_s && r_air_s) begin
                            take_l_s = !p_s;
                            take_r_s = p_s;
                            p_s      = !p_s;
                        end else begin
                            take_l_s = l_air_s;
                            take_r_s = r_air_s;
                        end
                        if (take_l_s) begin
                            f_s[(i == CELLS - 1) ? 0 : i + 1] = SAND_AM;
                            r_s[i] = AIR;
                            mv_s   = mv_s + MW'(1);
                        end else if (take_r_s) begin
                            if (i == 0) begin
                                carry_s = 1'b1;
                            end else begin
                                f_s[(i == 0) ? 0 : i - 1] = SAND_AM;
                            end
                            r_s[i] = AIR;
                            mv_s   = mv_s + MW'(1);
                        end else begin
                            r_s[i] = SAND;
                        end
                    end
                end
                default: r_s[i] = r_s[i];
            endcase
        end
        new_region = '0;
        new_floor  = '0;
        for (int i = 0; i < CELLS; i++) begin
            new_region[2*i +: 2] = pack_cell(r_s[i]);
            new_floor[2*i +: 2]  = pack_cell(f_s[i]);
        end
        carry     = carry_s;
        pref_next = p_s;
        moves     = mv_s;
    end

endmodule

// File: rtl/sand_row_stepper.sv
// Streaming sand-physics row stepper: one hold word of lookahead (H) feeding
// a registered output word (O), with cross-word carry, persistent tie-break
// preference and a saturating per-row moved-grain counter.
// Ports: clk, reset_n (async active-low), sclr (sync abort), bus (slave side
// of sand_row_stepper_if carrying both streams, dir_seed, row_done, moved_count).
module sand_row_stepper
    import sand_pkg::*;
#(
    parameter int CELLS = 16,
    parameter int CNT_W = 12
) (
    input logic              clk,
    input logic              reset_n,
    input logic              sclr,
    sand_row_stepper_if.slave bus
);

    localparam int MW = $clog2(CELLS + 1);

    logic               h_valid_r, h_first_r, h_last_r;
    logic [2*CELLS-1:0] h_region_r, h_floor_r;
    logic               o_valid_r, o_first_r, o_last_r;
    logic [2*CELLS-1:0] o_region_r, o_floor_r;
    logic               pref_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   moved_count_r;
    logic               row_done_r;

    logic               o_free_s, in_ready_s, accept_s, move_h_s, last_xfer_s, restart_s;
    cell_t              la_s;
    logic [2*CELLS-1:0] k_region_s, k_floor_s, floor_adj_s;
    logic               k_carry_s, k_pref_s;
    logic [MW-1:0]      k_moves_s;
    logic [CNT_W-1:0]   cnt_base_s, cnt_next_s;
    logic [CNT_W:0]     cnt_sum_s;

    assign o_free_s    = !o_valid_r || bus.out_ready;
    assign in_ready_s  = !(h_valid_r && h_last_r) && (!h_valid_r || o_free_s);
    assign accept_s    = bus.in_valid && in_ready_s;
    // H advances when its right neighbour arrives, or alone when it closes the row.
    assign move_h_s    = h_valid_r && (accept_s || h_last_r) && o_free_s;
    assign last_xfer_s = o_valid_r && bus.out_ready && o_last_r;
    assign restart_s   = accept_s && bus.in_first && h_valid_r && !h_last_r;
    // A new row never sees the previous row's cells, so it acts like a wall.
    assign la_s        = (h_last_r || bus.in_first) ? WALL
                                                    : unpack_cell(bus.in_floor[2*CELLS-1 -: 2]);

    sand_word_kernel #(.CELLS(CELLS), .MW(MW)) u_kernel (
        .cur_region (h_region_r),
        .cur_floor  (h_floor_r),
        .lookahead  (la_s),
        .pref       (pref_r),
        .new_region (k_region_s),
        .new_floor  (k_floor_s),
        .carry      (k_carry_s),
        .pref_next  (k_pref_s),
        .moves      (k_moves_s)
    );

    // Incoming floor word with the carried grain landed in its leftmost cell.
    always_comb begin
        floor_adj_s = bus.in_floor;
        if (move_h_s && k_carry_s) begin
            floor_adj_s[2*CELLS-1 -: 2] = pack_cell(SAND_AM);
        end else begin
            floor_adj_s[2*CELLS-1 -: 2] = bus.in_floor[2*CELLS-1 -: 2];
        end
    end

    // Next row count: restart after a row is reported, saturate at all-ones.
    always_comb begin
        cnt_base_s = last_xfer_s ? '0 : cnt_r;
        if (move_h_s) begin
            cnt_sum_s = {1'b0, cnt_base_s} + (CNT_W + 1)'(k_moves_s);
        end else begin
            cnt_sum_s = {1'b0, cnt_base_s};
        end
        if (restart_s) begin
            cnt_next_s = '0;
        end else if (cnt_sum_s[CNT_W]) begin
            cnt_next_s = '1;
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Hold register H and tie-break preference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_valid_r <= 1'b0; h_first_r <= 1'b0; h_last_r <= 1'b0;
            h_region_r <= '0;  h_floor_r <= '0;   pref_r <= 1'b0;
        end else if (sclr) begin
            h_valid_r <= 1'b0; h_first_r <= 1'b0; h_last_r <= 1'b0;
            h_region_r <= '0;  h_floor_r <= '0;   pref_r <= 1'b0;
        end else begin
            if (accept_s) begin
                h_valid_r  <= 1'b1;
                h_first_r  <= bus.in_first;
                h_last_r   <= bus.in_last;
                h_region_r <= bus.in_region;
                h_floor_r  <= floor_adj_s;
            end else if (move_h_s) begin
                h_valid_r <= 1'b0;
            end
            if (accept_s && bus.in_first) begin
                pref_r <= bus.dir_seed;
            end else if (move_h_s) begin
                pref_r <= k_pref_s;
            end
        end
    end

    // Output register O, row counter and row-done reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid_r <= 1'b0; o_first_r <= 1'b0; o_last_r <= 1'b0;
            o_region_r <= '0;  o_floor_r <= '0;
            cnt_r <= '0; moved_count_r <= '0; row_done_r <= 1'b0;
        end else if (sclr) begin
            o_valid_r <= 1'b0; o_first_r <= 1'b0; o_last_r <= 1'b0;
            o_region_r <= '0;  o_floor_r <= '0;
            cnt_r <= '0; moved_count_r <= '0; row_done_r <= 1'b0;
        end else begin
            if (move_h_s) begin
                o_valid_r  <= 1'b1;
                o_first_r  <= h_first_r;
                o_last_r   <= h_last_r;
                o_region_r <= k_region_s;
                o_floor_r  <= k_floor_s;
            end else if (bus.out_ready) begin
                o_valid_r <= 1'b0;
            end
            cnt_r      <= cnt_next_s;
            row_done_r <= last_xfer_s;
            if (last_xfer_s) begin
                moved_count_r <= cnt_r;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = o_valid_r;
    assign bus.out_region  = o_region_r;
    assign bus.out_floor   = o_floor_r;
    assign bus.out_first   = o_first_r;
    assign bus.out_last    = o_last_r;
    assign bus.row_done    = row_done_r;
    assign bus.moved_count = moved_count_r;

endmodule

// File: tb/tb_sand_row_stepper.sv
// Directed bench for sand_row_stepper with CELLS=4 (cells written 3..0).
module tb_sand_row_stepper;

    logic clk = 1'b0;
    logic reset_n;
    logic sclr;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sand_row_stepper_if #(.CELLS(4), .CNT_W(12)) bus ();

    sand_row_stepper #(.CELLS(4), .CNT_W(12)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sclr    (sclr),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] r, input logic [7:0] f, input logic fst, input logic lst);
        bus.in_valid  = 1'b1;
        bus.in_region = r;
        bus.in_floor  = f;
        bus.in_first  = fst;
        bus.in_last   = lst;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] r, input logic [7:0] f, input logic [1:0] tags);
        check({tag, ".valid"}, bus.out_valid, 1'b1);
        check({tag, ".region"}, bus.out_region, r);
        check({tag, ".floor"}, bus.out_floor, f);
        check({tag, ".tags"}, {bus.out_first, bus.out_last}, tags);
    endtask

    task automatic chk_done(input string tag, input logic [11:0] cnt);
        check({tag, ".row_done"}, bus.row_done, 1'b1);
        check({tag, ".count"}, bus.moved_count, cnt);
        check({tag, ".drained"}, bus.out_valid, 1'b0);
    endtask

    // Single-word row (first+last), out_ready held high.
    task automatic one_word_row(input string tag, input logic seed, input logic [7:0] r, input logic [7:0] f,
                                input logic [7:0] er, input logic [7:0] ef, input logic [11:0] cnt);
        bus.dir_seed = seed;
        put(r, f, 1'b1, 1'b1);
        check({tag, ".in_ready"}, bus.in_ready, 1'b1);
        tick();
        idle();
        check({tag, ".flush_stall"}, bus.in_ready, 1'b0);
        tick();
        chk_out(tag, er, ef, 2'b11);
        tick();
        chk_done(tag, cnt);
        tick();
        check({tag, ".pulse"}, bus.row_done, 1'b0);
    endtask

    // Two-word row, out_ready held high.
    task automatic two_word_row(input string tag, input logic [7:0] r0, input logic [7:0] f0,
                                input logic [7:0] r1, input logic [7:0] f1,
                                input logic [7:0] er0, input logic [7:0] ef0,
                                input logic [7:0] er1, input logic [7:0] ef1, input logic [11:0] cnt);
        bus.dir_seed = 1'b0;
        put(r0, f0, 1'b1, 1'b0);
        tick();
        put(r1, f1, 1'b0, 1'b1);
        check({tag, ".in_ready"}, bus.in_ready, 1'b1);
        tick();
        idle();
        chk_out({tag, ".w0"}, er0, ef0, 2'b10);
        tick();
        chk_out({tag, ".w1"}, er1, ef1, 2'b01);
        tick();
        chk_done(tag, cnt);
    endtask

    initial begin
        reset_n       = 1'b0;
        sclr          = 1'b0;
        bus.dir_seed  = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_region = 8'h00;
        bus.in_floor  = 8'h00;
        idle();
        #12;
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.row_done", bus.row_done, 1'b0);
        check("rst.count", bus.moved_count, 12'd0);
        check("rst.region", bus.out_region, 8'h00);
        reset_n = 1'b1;
        tick();
        check("rst.in_ready", bus.in_ready, 1'b1);

        // Straight fall: {S,A,A,A}/{A,A,A,A} -> {A,A,A,A}/{AM,A,A,A}
        one_word_row("fall", 1'b0, 8'b01_00_00_00, 8'b00_00_00_00, 8'b00_00_00_00, 8'b10_00_00_00, 12'd1);
        // Tie-break left then right
        one_word_row("tie0", 1'b0, 8'b00_01_00_00, 8'b00_11_00_11, 8'b00_00_00_00, 8'b10_11_00_11, 12'd1);
        one_word_row("tie1", 1'b1, 8'b00_01_00_00, 8'b00_11_00_11, 8'b00_00_00_00, 8'b00_11_10_11, 12'd1);
        // Carry into next word's leftmost floor cell
        two_word_row("carry", 8'b00_00_00_01, 8'b11_11_11_11, 8'b00_00_00_00, 8'b00_11_11_11,
                     8'b00_00_00_00, 8'b11_11_11_11, 8'b00_00_00_00, 8'b10_11_11_11, 12'd1);
        // No leftward cross-word move
        two_word_row("ledge", 8'b00_00_00_00, 8'b11_11_11_00, 8'b01_00_00_00, 8'b11_11_11_11,
                     8'b00_00_00_00, 8'b11_11_11_00, 8'b01_00_00_00, 8'b11_11_11_11, 12'd0);

        // Backpressure: three words, consumer stalled five cycles
        bus.out_ready = 1'b0;
        bus.dir_seed  = 1'b0;
        put(8'b01_00_00_00, 8'b00_00_00_00, 1'b1, 1'b0);
        tick();
        put(8'b00_01_00_00, 8'b00_11_11_11, 1'b0, 1'b0);
        check("bp.ready_w1", bus.in_ready, 1'b1);
        tick();
        put(8'b00_00_00_01, 8'b00_00_00_00, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check("bp.stall_ready", bus.in_ready, 1'b0);
            check("bp.stall_floor", bus.out_floor, 8'b10_00_00_00);
            tick();
        end
        chk_out("bp.w0", 8'b00_00_00_00, 8'b10_00_00_00, 2'b10);
        bus.out_ready = 1'b1;
        #1;
        check("bp.resume_ready", bus.in_ready, 1'b1);
        tick();
        idle();
        chk_out("bp.w1", 8'b00_00_00_00, 8'b10_11_11_11, 2'b00);
        tick();
        chk_out("bp.w2", 8'b00_00_00_00, 8'b00_00_00_10, 2'b01);
        tick();
        chk_done("bp", 12'd3);

        // Asynchronous reset mid-row
        bus.out_ready = 1'b0;
        put(8'b00_00_00_01, 8'b11_11_11_11, 1'b1, 1'b0);
        tick();
        put(8'b00_00_00_00, 8'b00_11_11_11, 1'b0, 1'b0);
        tick();
        idle();
        check("arst.pre_valid", bus.out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst.out_valid", bus.out_valid, 1'b0);
        check("arst.count", bus.moved_count, 12'd0);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        one_word_row("arst.tie1", 1'b1, 8'b00_01_00_00, 8'b00_11_00_11, 8'b00_00_00_00, 8'b00_11_10_11, 12'd1);

        // Synchronous abort mid-row, beating a handshake in the same cycle
        bus.out_ready = 1'b0;
        bus.dir_seed  = 1'b0;
        put(8'b00_00_00_01, 8'b11_11_11_11, 1'b1, 1'b0);
        tick();
        put(8'b00_00_00_00, 8'b00_11_11_11, 1'b0, 1'b0);
        tick();
        check("sclr.pre_valid", bus.out_valid, 1'b1);
        put(8'b01_00_00_00, 8'b00_00_00_00, 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        idle();
        check("sclr.out_valid", bus.out_valid, 1'b0);
        check("sclr.in_ready", bus.in_ready, 1'b1);
        check("sclr.row_done", bus.row_done, 1'b0);
        tick();
        check("sclr.no_flush", bus.out_valid, 1'b0);
        one_word_row("sclr.tie1", 1'b1, 8'b00_01_00_00, 8'b00_11_00_11, 8'b00_00_00_00, 8'b00_11_10_11, 12'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
